// File: rtl/cal_pkg.sv
// Shared definitions for the calibration neighbour/delta pipeline:
// scan-area and shift-select one-hot codes, FSM encoding and the
// scan-area classification helper.
package cal_pkg;

  // Scan-area one-hot codes
  localparam logic [4:0] SA_INI  = 5'b00001;
  localparam logic [4:0] SA_INT  = 5'b00010;
  localparam logic [4:0] SA_ROW0 = 5'b00100;
  localparam logic [4:0] SA_COL0 = 5'b01000;
  localparam logic [4:0] SA_LAST = 5'b10000;

  // Shift-select one-hot codes
  localparam logic [3:0] SL_9 = 4'b0001;
  localparam logic [3:0] SL_6 = 4'b0010;
  localparam logic [3:0] SL_3 = 4'b0100;
  localparam logic [3:0] SL_0 = 4'b1000;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Classify a sample position; the first matching rule wins so that the
  // top-left corner is INI and a single-column frame reports col0 below row 0.
  function automatic logic [4:0] scan_area(input logic x_first,
                                           input logic y_first,
                                           input logic x_last);
    logic [4:0] sa;
    if (x_first && y_first) begin
      sa = SA_INI;
    end else if (y_first) begin
      sa = SA_ROW0;
    end else if (x_first) begin
      sa = SA_COL0;
    end else if (x_last) begin
      sa = SA_LAST;
    end else begin
      sa = SA_INT;
    end
    return sa;
  endfunction

endpackage

// File: rtl/nbr_line_buf.sv
// One-row line buffer: synchronous write, two asynchronous reads so the
// north and north-east neighbours are available in the same cycle that the
// current sample overwrites the north position.
module nbr_line_buf
  import cal_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int NX_MAX     = 1024,
  parameter int X_W        = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [X_W-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [X_W-1:0]        rd_addr_a,
  input  logic [X_W-1:0]        rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  localparam int             AW    = (NX_MAX > 1) ? $clog2(NX_MAX) : 1;
  localparam logic [X_W-1:0] DEPTH = X_W'(NX_MAX);

  logic [DATA_WIDTH-1:0] mem_r [NX_MAX];

  // Store the accepted sample at its column; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH)) begin
      mem_r[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Read both columns combinationally; an address past the end returns zero.
  always_comb begin
    rd_data_a = {DATA_WIDTH{1'b0}};
    rd_data_b = {DATA_WIDTH{1'b0}};
    if (rd_addr_a < DEPTH) begin
      rd_data_a = mem_r[rd_addr_a[AW-1:0]];
    end else begin
      rd_data_a = {DATA_WIDTH{1'b0}};
    end
    if (rd_addr_b < DEPTH) begin
      rd_data_b = mem_r[rd_addr_b[AW-1:0]];
    end else begin
      rd_data_b = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/cal_nbr_gen.sv
// Neighbour generator: walks a BSQ sample stream, keeps the previous row of
// the current band and presents each sample with its N/NE/NW/W neighbours,
// the scan-area code and the latched shift selector, one cycle after accept.
module cal_nbr_gen
  import cal_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int NX_MAX     = 1024,
  parameter int X_W        = 11,
  parameter int Y_W        = 16,
  parameter int Z_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [X_W-1:0]        nx_i,
  input  logic [Y_W-1:0]        ny_i,
  input  logic [Z_W-1:0]        nz_i,
  input  logic [3:0]            sl_num_i,
  input  logic [DATA_WIDTH-1:0] s_i,
  input  logic                  s_vld_i,
  output logic                  en_o,
  output logic [DATA_WIDTH-1:0] S_o,
  output logic [DATA_WIDTH-1:0] Sn_o,
  output logic [DATA_WIDTH-1:0] Sne_o,
  output logic [DATA_WIDTH-1:0] Snw_o,
  output logic [DATA_WIDTH-1:0] cj_fst_o,
  output logic [4:0]            scan_area_o,
  output logic [3:0]            sl_num_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [DATA_WIDTH-1:0] ZERO_D = {DATA_WIDTH{1'b0}};

  state_e state_r;
  state_e state_nxt_s;

  logic [X_W-1:0]        nx_r;
  logic [Y_W-1:0]        ny_r;
  logic [Z_W-1:0]        nz_r;
  logic [X_W-1:0]        x_r;
  logic [Y_W-1:0]        y_r;
  logic [Z_W-1:0]        z_r;
  logic [DATA_WIDTH-1:0] prev_n_r;   // north of the previous sample = NW of this one
  logic [DATA_WIDTH-1:0] prev_s_r;   // previous sample = W of this one

  logic                  start_ok_s;
  logic                  accept_s;
  logic                  x_first_s;
  logic                  y_first_s;
  logic                  x_last_s;
  logic                  y_last_s;
  logic                  z_last_s;
  logic                  frame_end_s;
  logic [X_W-1:0]        addr_ne_s;
  logic [DATA_WIDTH-1:0] rd_n_s;
  logic [DATA_WIDTH-1:0] rd_ne_s;
  logic [DATA_WIDTH-1:0] n_nxt_s;
  logic [DATA_WIDTH-1:0] ne_nxt_s;
  logic [DATA_WIDTH-1:0] nw_nxt_s;
  logic [DATA_WIDTH-1:0] w_nxt_s;
  logic [4:0]            area_nxt_s;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;

  // Position decode and accept qualification.
  always_comb begin
    start_ok_s  = (state_r == ST_IDLE) && start_i;
    accept_s    = (state_r == ST_RUN) && s_vld_i;
    x_first_s   = (x_r == {X_W{1'b0}});
    y_first_s   = (y_r == {Y_W{1'b0}});
    x_last_s    = (x_r == (nx_r - X_W'(1)));
    y_last_s    = (y_r == (ny_r - Y_W'(1)));
    z_last_s    = (z_r == (nz_r - Z_W'(1)));
    frame_end_s = accept_s && x_last_s && y_last_s && z_last_s;
    addr_ne_s   = x_r + X_W'(1);
  end

  nbr_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NX_MAX     (NX_MAX),
    .X_W        (X_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (accept_s),
    .wr_addr   (x_r),
    .wr_data   (s_i),
    .rd_addr_a (x_r),
    .rd_addr_b (addr_ne_s),
    .rd_data_a (rd_n_s),
    .rd_data_b (rd_ne_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: start only from IDLE, finish on the last sample of the last band.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: busy tracks RUN; done is a one-cycle pulse following DONE.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN:  busy_nxt_s = 1'b1;
      default: busy_nxt_s = 1'b0;
    endcase
    case (state_r)
      ST_DONE: done_nxt_s = 1'b1;
      default: done_nxt_s = 1'b0;
    endcase
  end

  // Register the status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= busy_nxt_s;
      done_o <= done_nxt_s;
    end
  end

  // Latch the frame geometry and shift select when a frame is started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nx_r     <= {X_W{1'b0}};
      ny_r     <= {Y_W{1'b0}};
      nz_r     <= {Z_W{1'b0}};
      sl_num_o <= 4'b0000;
    end else if (start_ok_s) begin
      nx_r     <= nx_i;
      ny_r     <= ny_i;
      nz_r     <= nz_i;
      sl_num_o <= sl_num_i;
    end
  end

  // Raster position: x fastest, then row, then band.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
      z_r <= {Z_W{1'b0}};
    end else if (start_ok_s) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
      z_r <= {Z_W{1'b0}};
    end else if (accept_s) begin
      if (x_last_s) begin
        x_r <= {X_W{1'b0}};
        if (y_last_s) begin
          y_r <= {Y_W{1'b0}};
          z_r <= z_r + Z_W'(1);
        end else begin
          y_r <= y_r + Y_W'(1);
        end
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  // Remember the current sample and its north value for the next sample in the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_n_r <= ZERO_D;
      prev_s_r <= ZERO_D;
    end else if (accept_s) begin
      prev_n_r <= rd_n_s;
      prev_s_r <= s_i;
    end
  end

  // Select neighbours, forcing zero where the neighbour lies outside the band.
  always_comb begin
    n_nxt_s    = ZERO_D;
    ne_nxt_s   = ZERO_D;
    nw_nxt_s   = ZERO_D;
    w_nxt_s    = ZERO_D;
    area_nxt_s = scan_area(x_first_s, y_first_s, x_last_s);
    if (y_first_s) begin
      n_nxt_s  = ZERO_D;
      ne_nxt_s = ZERO_D;
      nw_nxt_s = ZERO_D;
    end else begin
      n_nxt_s = rd_n_s;
      if (x_last_s) begin
        ne_nxt_s = ZERO_D;
      end else begin
        ne_nxt_s = rd_ne_s;
      end
      if (x_first_s) begin
        nw_nxt_s = ZERO_D;
      end else begin
        nw_nxt_s = prev_n_r;
      end
    end
    if (x_first_s) begin
      w_nxt_s = ZERO_D;
    end else begin
      w_nxt_s = prev_s_r;
    end
  end

  // Register the sample and its neighbourhood; data holds while no sample is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_o        <= 1'b0;
      S_o         <= ZERO_D;
      Sn_o        <= ZERO_D;
      Sne_o       <= ZERO_D;
      Snw_o       <= ZERO_D;
      cj_fst_o    <= ZERO_D;
      scan_area_o <= 5'b00000;
    end else begin
      en_o <= accept_s;
      if (accept_s) begin
        S_o         <= s_i;
        Sn_o        <= n_nxt_s;
        Sne_o       <= ne_nxt_s;
        Snw_o       <= nw_nxt_s;
        cj_fst_o    <= w_nxt_s;
        scan_area_o <= area_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_cal_nbr_gen.sv
// Self-checking bench for cal_nbr_gen: frames are described as a 3-D sample
// array and expected neighbours come straight from array positions.
module tb_cal_nbr_gen;

  localparam int DW = 12;
  localparam int XW = 11;
  localparam int YW = 16;
  localparam int ZW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [XW-1:0] nx_i = '0;
  logic [YW-1:0] ny_i = '0;
  logic [ZW-1:0] nz_i = '0;
  logic [3:0]    sl_num_i = 4'b0000;
  logic [DW-1:0] s_i = '0;
  logic          s_vld_i = 1'b0;
  logic          en_o;
  logic [DW-1:0] S_o, Sn_o, Sne_o, Snw_o, cj_fst_o;
  logic [4:0]    scan_area_o;
  logic [3:0]    sl_num_o;
  logic          busy_o, done_o;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] frame_d [0:4095];
  logic [71:0]   obs     [0:4095];   // {S,N,NE,NW,W,area} captured per sample index

  cal_nbr_gen #(.DATA_WIDTH(DW), .NX_MAX(1024), .X_W(XW), .Y_W(YW), .Z_W(ZW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .nx_i(nx_i), .ny_i(ny_i), .nz_i(nz_i),
    .sl_num_i(sl_num_i), .s_i(s_i), .s_vld_i(s_vld_i), .en_o(en_o), .S_o(S_o),
    .Sn_o(Sn_o), .Sne_o(Sne_o), .Snw_o(Snw_o), .cj_fst_o(cj_fst_o),
    .scan_area_o(scan_area_o), .sl_num_o(sl_num_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input int nx, input int ny, input int x, input int y, input int z);
    return frame_d[(z * ny + y) * nx + x];
  endfunction

  // Drive one frame; check every output against positional expectations.
  task automatic run_frame(input int nx, input int ny, input int nz, input int gmin, input int gmax,
                           input bit vld_with_start, input int mid_start_at, input logic [3:0] sl);
    int n;
    int en_cnt;
    logic [DW-1:0] last_s;
    n = nx * ny * nz;
    en_cnt = 0;
    last_s = '0;
    @(negedge clk);
    nx_i = XW'(nx); ny_i = YW'(ny); nz_i = ZW'(nz); sl_num_i = sl;
    start_i = 1'b1; s_vld_i = vld_with_start; s_i = 12'hABC;
    @(negedge clk);
    start_i = 1'b0; s_vld_i = 1'b0;
    total++;
    if (busy_o !== 1'b1 || en_o !== 1'b0) begin
      bad++; $display("FAIL start_busy got busy=%b en=%b want busy=1 en=0", busy_o, en_o);
    end
    for (int i = 0; i < n; i++) begin
      int x, y, z, g;
      logic [DW-1:0] e_n, e_ne, e_nw, e_w;
      logic [4:0] e_a;
      logic [75:0] got, want;
      x = i % nx; y = (i / nx) % ny; z = i / (nx * ny);
      g = $urandom_range(gmax, gmin);
      for (int k = 0; k < g; k++) begin
        s_vld_i = 1'b0; s_i = DW'($urandom);
        @(negedge clk);
        total++;
        if (en_o !== 1'b0 || (i > 0 && S_o !== last_s)) begin
          bad++; $display("FAIL gap_hold[%0d] got en=%b S=%0d want en=0 S=%0d", i, en_o, S_o, last_s);
        end
      end
      s_vld_i = 1'b1; s_i = frame_d[i];
      if (i == mid_start_at) begin
        start_i = 1'b1; nx_i = XW'(2); ny_i = YW'(1); nz_i = ZW'(1); sl_num_i = ~sl;
      end
      @(negedge clk);
      start_i = 1'b0; s_vld_i = 1'b0;
      en_cnt += (en_o === 1'b1) ? 1 : 0;
      e_n  = (y > 0) ? pix(nx, ny, x, y - 1, z) : '0;
      e_ne = (y > 0 && x < nx - 1) ? pix(nx, ny, x + 1, y - 1, z) : '0;
      e_nw = (y > 0 && x > 0) ? pix(nx, ny, x - 1, y - 1, z) : '0;
      e_w  = (x > 0) ? pix(nx, ny, x - 1, y, z) : '0;
      if (x == 0 && y == 0)  e_a = 5'b00001;
      else if (y == 0)       e_a = 5'b00100;
      else if (x == 0)       e_a = 5'b01000;
      else if (x == nx - 1)  e_a = 5'b10000;
      else                   e_a = 5'b00010;
      obs[i] = {S_o, Sn_o, Sne_o, Snw_o, cj_fst_o, scan_area_o, 7'd0};
      got  = {en_o, S_o, Sn_o, Sne_o, Snw_o, cj_fst_o, scan_area_o, sl_num_o, busy_o, 1'b0, 1'b0};
      want = {1'b1, frame_d[i], e_n, e_ne, e_nw, e_w, e_a, sl, (i < n - 1) ? 1'b1 : 1'b0, 1'b0, 1'b0};
      total++;
      if (got !== want || done_o !== 1'b0) begin
        bad++; $display("FAIL sample[%0d] (x=%0d y=%0d z=%0d) got=%h done=%b want=%h done=0", i, x, y, z, got, done_o, want);
      end
      last_s = frame_d[i];
    end
    @(negedge clk);
    total++;
    if (done_o !== 1'b1 || en_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL done_pulse got done=%b en=%b busy=%b want 1 0 0", done_o, en_o, busy_o);
    end
    @(negedge clk);
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL done_width got=%b want=0", done_o);
    end
    total++;
    if (en_cnt != n) begin
      bad++; $display("FAIL en_count got=%0d want=%0d", en_cnt, n);
    end
  endtask

  task automatic fill_rows(input int nx, input int ny, input int nz, input int bandk, input int off);
    for (int z = 0; z < nz; z++)
      for (int y = 0; y < ny; y++)
        for (int x = 0; x < nx; x++)
          frame_d[(z * ny + y) * nx + x] = DW'(bandk * z + 10 * y + x + off);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({en_o, S_o, Sn_o, Sne_o, Snw_o, cj_fst_o, scan_area_o, sl_num_o, busy_o, done_o} !== 72'd0) begin
      bad++; $display("FAIL reset_state got en=%b S=%0d area=%b sl=%b busy=%b done=%b want all 0",
                      en_o, S_o, scan_area_o, sl_num_o, busy_o, done_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fill_rows(4, 3, 1, 0, 0);
    run_frame(4, 3, 1, 0, 0, 1'b0, -1, 4'b0100);
    total++;
    if (obs[6][71:7] !== {12'd12, 12'd2, 12'd3, 12'd1, 12'd11, 5'b00010}) begin
      bad++; $display("FAIL interior_2_1 got=%h want S=12 N=2 NE=3 NW=1 W=11 area=00010", obs[6][71:7]);
    end
    total++;
    if (obs[4][11:7] !== 5'b01000 || obs[4][35:12] !== 24'd0) begin
      bad++; $display("FAIL col0_0_1 got area=%b nw_w=%h want area=01000 nw_w=0", obs[4][11:7], obs[4][35:12]);
    end
    total++;
    if (obs[7][11:7] !== 5'b10000 || obs[7][47:36] !== 12'd0) begin
      bad++; $display("FAIL last_3_1 got area=%b ne=%0d want area=10000 ne=0", obs[7][11:7], obs[7][47:36]);
    end
    total++;
    if (obs[0][11:7] !== 5'b00001 || obs[0][59:12] !== 48'd0) begin
      bad++; $display("FAIL ini_0_0 got area=%b nbrs=%h want area=00001 nbrs=0", obs[0][11:7], obs[0][59:12]);
    end
    total++;
    if (obs[1][11:7] !== 5'b00100 || obs[1][23:12] !== 12'd0 || obs[1][59:48] !== 12'd0) begin
      bad++; $display("FAIL row0_1_0 got area=%b W=%0d N=%0d want area=00100 W=0 N=0",
                      obs[1][11:7], obs[1][23:12], obs[1][59:48]);
    end
  endtask

  task automatic test_single_col();
    fill_rows(1, 3, 2, 100, 1);
    run_frame(1, 3, 2, 0, 0, 1'b0, -1, 4'b0001);
    total++;
    if (obs[1][11:7] !== 5'b01000 || obs[1][47:36] !== 12'd0) begin
      bad++; $display("FAIL nx1_col0 got area=%b ne=%0d want area=01000 ne=0", obs[1][11:7], obs[1][47:36]);
    end
    total++;
    if (obs[3][11:7] !== 5'b00001 || obs[3][59:48] !== 12'd0) begin
      bad++; $display("FAIL band1_ini got area=%b N=%0d want area=00001 N=0", obs[3][11:7], obs[3][59:48]);
    end
  endtask

  task automatic test_gapped();
    fill_rows(4, 3, 1, 0, 0);
    run_frame(4, 3, 1, 2, 2, 1'b0, -1, 4'b1000);
    total++;
    if (obs[6][71:7] !== {12'd12, 12'd2, 12'd3, 12'd1, 12'd11, 5'b00010}) begin
      bad++; $display("FAIL gapped_2_1 got=%h want S=12 N=2 NE=3 NW=1 W=11 area=00010", obs[6][71:7]);
    end
  endtask

  task automatic test_ignore();
    fill_rows(4, 3, 1, 0, 5);
    run_frame(4, 3, 1, 0, 1, 1'b1, 5, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_vld_i = 1'b1; s_i = DW'($urandom);
      @(negedge clk);
      s_vld_i = 1'b0;
      total++;
      if (en_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL idle_vld[%0d] got en=%b busy=%b want 0 0", k, en_o, busy_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_rows(4, 3, 1, 0, 1);
    @(negedge clk);
    nx_i = XW'(4); ny_i = YW'(3); nz_i = ZW'(1); sl_num_i = 4'b0100; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_vld_i = 1'b1; s_i = frame_d[i];
      @(negedge clk);
    end
    s_vld_i = 1'b0;
    total++;
    if (S_o !== 12'd11 || en_o !== 1'b1) begin
      bad++; $display("FAIL pre_reset got S=%0d en=%b want S=11 en=1", S_o, en_o);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({en_o, S_o, Sn_o, Sne_o, Snw_o, cj_fst_o, scan_area_o, sl_num_o, busy_o, done_o} !== 72'd0) begin
      bad++; $display("FAIL mid_reset got en=%b S=%0d area=%b sl=%b busy=%b want all 0",
                      en_o, S_o, scan_area_o, sl_num_o, busy_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL post_reset[%0d] got done=%b busy=%b want 0 0", k, done_o, busy_o);
      end
    end
    fill_rows(4, 3, 1, 0, 7);
    run_frame(4, 3, 1, 0, 0, 1'b0, -1, 4'b0001);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int nx, ny, nz;
      logic [3:0] sl;
      nx = $urandom_range(8, 1); ny = $urandom_range(4, 1); nz = $urandom_range(3, 1);
      sl = 4'b0001 << $urandom_range(3, 0);
      for (int i = 0; i < nx * ny * nz; i++) frame_d[i] = DW'($urandom);
      run_frame(nx, ny, nz, 0, 2, 1'b0, -1, sl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_col();
    test_gapped();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
